// File: rtl/addr_mod.sv
// addr_mod: target addressing constants shared by initiator and target.
// Latency: n/a (constants only).
// Backpressure: n/a.
package addr_mod;

  // Address increment the target applies after each issued beat.
  localparam int STRIDE = 1;

endpackage

// File: rtl/bt_top.sv
// bt_top: bus widths, address limit and burst FSM state type for burst_initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bt_top;

  localparam int ADDR_WIDTH = 8;
  localparam int DATA_WIDTH = 16;
  // Highest address a burst may touch; bursts running past it are rejected.
  localparam int ADDR_MAX   = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2,
    RD_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/rd_latency_pipe.sv
// rd_latency_pipe: delays read-issue valid/last flags to line up with target read data.
// Latency: DEPTH cycles from issue to rdo_valid; data is the target rd_data passed through.
// Backpressure: none; every issued read yields exactly one output beat.
// Ports: clk/rstn; issue_vld/issue_last from the FSM; rd_data from target; rdo_* to requester.
module rd_latency_pipe #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              issue_vld,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rdo_valid,
  output logic              rdo_last,
  output logic [DATA_W-1:0] rdo_data
);

  logic [DEPTH-1:0] vld_sr;
  logic [DEPTH-1:0] last_sr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_sr  <= '0;
      last_sr <= '0;
    end else begin
      vld_sr[0]  <= issue_vld;
      last_sr[0] <= issue_vld && issue_last;
      for (int i = 1; i < DEPTH; i++) begin
        vld_sr[i]  <= vld_sr[i-1];
        last_sr[i] <= last_sr[i-1];
      end
    end
  end

  assign rdo_valid = vld_sr[DEPTH-1];
  assign rdo_last  = last_sr[DEPTH-1];
  // Masking keeps rdo_data at zero between beats and through reset.
  assign rdo_data  = rdo_valid ? rd_data : '0;

endmodule

// File: rtl/burst_initiator.sv
// burst_initiator: accepts read/write burst commands and drives a self-incrementing target.
// Latency: burst starts the cycle after accept; read beats return RD_LATENCY cycles after rden.
// Backpressure: cmd_ready only in IDLE; write stream stalls on wd_valid; read output has none.
// Ports: cmd_* command channel, wd_* write stream, rdo_* read stream, busy status,
//        burst_en/addr_top/wren/rden/wr_data/rd_data target side.
module burst_initiator
  import bt_top::*;
  import addr_mod::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [ADDR_WIDTH-1:0]      cmd_addr,
  input  logic [$clog2(MAX_LEN):0]   cmd_len,
  output logic                       cmd_err,
  input  logic                       wd_valid,
  output logic                       wd_ready,
  input  logic [DATA_WIDTH-1:0]      wd_data,
  output logic                       rdo_valid,
  output logic [DATA_WIDTH-1:0]      rdo_data,
  output logic                       rdo_last,
  output logic                       busy,
  output logic                       burst_en,
  output logic [ADDR_WIDTH-1:0]      addr_top,
  output logic                       wren,
  output logic                       rden,
  output logic [DATA_WIDTH-1:0]      wr_data,
  input  logic [DATA_WIDTH-1:0]      rd_data
);

  localparam int LEN_W = $clog2(MAX_LEN) + 1;
  // Wide enough that the end-address sum can never wrap.
  localparam int SUM_W = ADDR_WIDTH + LEN_W;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] beat_cnt;
  logic [SUM_W-1:0] end_addr;
  logic             len_bad, addr_bad, cmd_ok, cmd_fire, last_beat;

  assign end_addr  = SUM_W'(cmd_addr) + SUM_W'(cmd_len - LEN_W'(1)) * SUM_W'(STRIDE);
  assign len_bad   = (cmd_len == '0) || (cmd_len > LEN_W'(MAX_LEN));
  assign addr_bad  = end_addr > SUM_W'(ADDR_MAX);
  assign cmd_ok    = !len_bad && !addr_bad;
  assign cmd_fire  = cmd_valid && cmd_ready;
  // Counter holds the beats still to issue, so 1 marks the final beat.
  assign last_beat = (beat_cnt == LEN_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (cmd_fire && cmd_ok) state_nxt = cmd_write ? WR_BURST : RD_BURST;
      WR_BURST: if (wd_valid && last_beat) state_nxt = IDLE;
      RD_BURST: if (last_beat) state_nxt = RD_DRAIN;
      RD_DRAIN: if (rdo_last) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    burst_en  = 1'b1;
    wd_ready  = 1'b0;
    wren      = 1'b0;
    rden      = 1'b0;
    wr_data   = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        burst_en  = 1'b0;
      end
      WR_BURST: begin
        wd_ready = 1'b1;
        wren     = wd_valid;
        wr_data  = wd_data;
      end
      RD_BURST: rden = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= '0;
      addr_top <= '0;
    end else if (cmd_fire && cmd_ok) begin
      beat_cnt <= cmd_len;
      addr_top <= cmd_addr;
    end else if (wren || rden) begin
      beat_cnt <= beat_cnt - LEN_W'(1);
    end
  end

  // Registered so a rejection shows as a clean one-cycle pulse after the handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cmd_err <= 1'b0;
    else       cmd_err <= cmd_fire && !cmd_ok;
  end

  rd_latency_pipe #(
    .DEPTH  (RD_LATENCY),
    .DATA_W (DATA_WIDTH)
  ) u_rd_pipe (
    .clk        (clk),
    .rstn       (rstn),
    .issue_vld  (rden),
    .issue_last (rden && last_beat),
    .rd_data    (rd_data),
    .rdo_valid  (rdo_valid),
    .rdo_last   (rdo_last),
    .rdo_data   (rdo_data)
  );

endmodule

// File: tb/tb_burst_initiator.sv
module tb_burst_initiator;
  import bt_top::*;
  import addr_mod::*;

  localparam int MAXL  = 16;
  localparam int RDL   = 2;
  localparam int LW    = $clog2(MAXL) + 1;
  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int NADDR = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          cmd_valid, cmd_ready, cmd_write, cmd_err;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rdo_valid, rdo_last, busy, burst_en, wren, rden;
  logic [DW-1:0] rdo_data, wr_data, rd_data;
  logic [AW-1:0] addr_top;

  always #5 clk = ~clk;

  burst_initiator #(.MAX_LEN(MAXL), .RD_LATENCY(RDL)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rdo_valid(rdo_valid), .rdo_data(rdo_data), .rdo_last(rdo_last),
    .busy(busy), .burst_en(burst_en), .addr_top(addr_top),
    .wren(wren), .rden(rden), .wr_data(wr_data), .rd_data(rd_data)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 37 + 'h1B00);
  endfunction

  // Target: memory that starts at addr_top and steps by STRIDE per issued beat.
  logic [DW-1:0] tmem [NADDR];
  logic [DW-1:0] rd_sr [RDL];
  int            off;
  logic [AW-1:0] tgt_addr;
  assign tgt_addr = AW'(int'(addr_top) + off * STRIDE);
  assign rd_data  = rd_sr[RDL-1];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NADDR; i++) tmem[i] <= init_val(i);
      for (int i = 0; i < RDL; i++) rd_sr[i] <= '0;
      off <= 0;
    end else begin
      if (!burst_en) off <= 0;
      else if (wren || rden) off <= off + 1;
      if (wren) tmem[tgt_addr] <= wr_data;
      rd_sr[0] <= tmem[tgt_addr];
      for (int i = 1; i < RDL; i++) rd_sr[i] <= rd_sr[i-1];
    end
  end

  // Observers
  int            wren_cnt = 0, rden_cnt = 0, rdo_cnt = 0, both_cnt = 0, idle_viol = 0;
  logic [AW-1:0] last_addr = '0;
  logic [DW:0]   rdo_q [$];

  always @(posedge clk) begin
    if (rstn) begin
      if (wren) wren_cnt <= wren_cnt + 1;
      if (rden) rden_cnt <= rden_cnt + 1;
      if (wren || rden) last_addr <= tgt_addr;
      if (wren && rden) both_cnt <= both_cnt + 1;
      if (!busy && (wren || rden || burst_en)) idle_viol <= idle_viol + 1;
      if (rdo_valid) begin
        rdo_cnt <= rdo_cnt + 1;
        rdo_q.push_back({rdo_last, rdo_data});
      end
    end
  end

  // Reference model: flat memory plus the legality rule in plain arithmetic.
  logic [DW-1:0] ref_mem [NADDR];
  logic [DW-1:0] wdata [MAXL];
  int            wr_cycles;

  function automatic bit cmd_legal(input int addr, input int len);
    return (len >= 1) && (len <= MAXL) && (addr + (len - 1) * STRIDE <= ADDR_MAX);
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < NADDR; i++) ref_mem[i] = init_val(i);
  endtask

  task automatic run_cmd(input bit wr, input int addr, input int len,
                         input bit rand_stall, input logic [31:0] stall_mask);
    int w0, r0, cyc, beat;
    bit ok, v;
    ok = cmd_legal(addr, len);
    w0 = wren_cnt;
    r0 = rden_cnt;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = AW'(addr);
    cmd_len   = LW'(len);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!ok) begin
      chk("rej_cmd_err", cmd_err, 1);
      chk("rej_busy", busy, 0);
      @(negedge clk);
      chk("rej_err_one_cycle", cmd_err, 0);
      chk("rej_busy_after", busy, 0);
      chk("rej_no_wren", wren_cnt - w0, 0);
      chk("rej_no_rden", rden_cnt - r0, 0);
      return;
    end
    chk("acc_busy", busy, 1);
    chk("acc_no_err", cmd_err, 0);
    chk("acc_addr_top", addr_top, addr);
    if (wr) begin
      beat = 0;
      cyc  = 0;
      while (beat < len && cyc < 200) begin
        v = rand_stall ? ($urandom_range(0, 3) != 0) : ((cyc < 32) ? !stall_mask[cyc] : 1'b1);
        wd_valid = v;
        wd_data  = v ? wdata[beat] : DW'($urandom);
        #1;
        chk("wd_ready", wd_ready, 1);
        chk("wr_burst_en", burst_en, 1);
        chk("wren_follows_valid", wren, v);
        @(negedge clk);
        if (v) beat++;
        cyc++;
      end
      wd_valid  = 1'b0;
      wr_cycles = cyc;
      chk("wr_beats_in_budget", beat, len);
      chk("wr_idle_after_last", busy, 0);
      chk("wren_count", wren_cnt - w0, len);
      chk("wr_no_rden", rden_cnt - r0, 0);
      for (int i = 0; i < len; i++) ref_mem[addr + i * STRIDE] = wdata[i];
    end else begin
      rdo_q.delete();
      cyc = 0;
      while (busy && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      chk("rd_busy_cycles", cyc, len + RDL);
      chk("rden_count", rden_cnt - r0, len);
      chk("rd_no_wren", wren_cnt - w0, 0);
      chk("rdo_beats", rdo_q.size(), len);
      for (int i = 0; i < len && i < rdo_q.size(); i++) begin
        chk("rdo_data", rdo_q[i][DW-1:0], ref_mem[addr + i * STRIDE]);
        chk("rdo_last", rdo_q[i][DW], i == len - 1);
      end
    end
  endtask

  initial begin
    int a, l, c0;
    bit w;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0;
    ref_reset();

    // Reset values
    #1 rstn = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_burst_en", burst_en, 0);
    chk("rst_wren", wren, 0);
    chk("rst_rden", rden, 0);
    chk("rst_rdo_valid", rdo_valid, 0);
    chk("rst_rdo_last", rdo_last, 0);
    chk("rst_cmd_err", cmd_err, 0);
    chk("rst_addr_top", addr_top, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_rdo_data", rdo_data, 0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1);

    // Write A0..A3 at 0, then read back
    for (int i = 0; i < 4; i++) wdata[i] = DW'('hA0 + i);
    run_cmd(1'b1, 0, 4, 1'b0, 32'h0);
    chk("wr4_cycles", wr_cycles, 4);
    run_cmd(1'b0, 0, 4, 1'b0, 32'h0);

    // Stall on the second cycle of a 3-beat write
    for (int i = 0; i < 3; i++) wdata[i] = DW'($urandom);
    run_cmd(1'b1, 16, 3, 1'b0, 32'h2);
    chk("stall_cycles", wr_cycles, 4);
    run_cmd(1'b0, 16, 3, 1'b0, 32'h0);

    // Bound check: one beat past ADDR_MAX
    run_cmd(1'b1, ADDR_MAX - 1, 3, 1'b0, 32'h0);
    run_cmd(1'b0, ADDR_MAX - 1, 3, 1'b0, 32'h0);

    // Boundary fit ending exactly at ADDR_MAX
    for (int i = 0; i < 4; i++) wdata[i] = DW'($urandom);
    run_cmd(1'b1, ADDR_MAX - 3, 4, 1'b0, 32'h0);
    chk("fit_wr_last_addr", last_addr, ADDR_MAX);
    run_cmd(1'b0, ADDR_MAX - 3, 4, 1'b0, 32'h0);
    chk("fit_rd_last_addr", last_addr, ADDR_MAX);

    // Invalid lengths, then the longest legal burst
    run_cmd(1'b1, 5, 0, 1'b0, 32'h0);
    run_cmd(1'b0, 5, MAXL + 1, 1'b0, 32'h0);
    run_cmd(1'b0, 0, MAXL, 1'b0, 32'h0);

    // Randomized commands against the reference model
    repeat (30) begin
      w = 1'(($urandom_range(0, 1)));
      l = int'($urandom_range(0, MAXL + 1));
      if ($urandom_range(0, 3) == 0) a = ADDR_MAX - int'($urandom_range(0, MAXL));
      else a = int'($urandom_range(0, ADDR_MAX));
      for (int i = 0; i < MAXL; i++) wdata[i] = DW'($urandom);
      run_cmd(w, a, l, 1'b1, 32'h0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during beat 2 of an 8-beat read
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(40); cmd_len = LW'(8);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_rden_active", rden, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_burst_en", burst_en, 0);
    chk("mid_rst_rden", rden, 0);
    chk("mid_rst_wren", wren, 0);
    chk("mid_rst_rdo_valid", rdo_valid, 0);
    chk("mid_rst_addr_top", addr_top, 0);
    ref_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("mid_rel_cmd_ready", cmd_ready, 1);
    chk("mid_rel_busy", busy, 0);
    c0 = rdo_cnt;
    repeat (12) @(negedge clk);
    chk("mid_no_stray_rdo", rdo_cnt - c0, 0);
    run_cmd(1'b0, 40, 8, 1'b0, 32'h0);

    // Global invariants
    chk("never_wren_and_rden", both_cnt, 0);
    chk("idle_outputs_quiet", idle_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
